// File: rtl/wishbone_reg_bank.sv
// Wishbone classic slave register bank. Each register is read/write control,
// read-only hardware status, or write-1-to-clear event. The bank gives a
// registered single-cycle ack, and an err for unmapped addresses and RO writes.
//
// state | meaning
// IDLE  | waiting for wbCycI & wbStbI; the access is performed on that edge
// RESP  | one cycle with wbAckO or wbErrO high, then back to IDLE
module wishbone_reg_bank #(
  parameter int                     ADDR_WIDTH = 24,
  parameter int                     DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 24'hA00000,
  parameter int                     DEPTH      = 16,
  parameter logic [DEPTH-1:0]       RO_MASK    = '0,
  parameter logic [DEPTH-1:0]       W1C_MASK   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       wbAdrI,
  input  logic [DATA_WIDTH-1:0]       wbDatI,
  output logic [DATA_WIDTH-1:0]       wbDatO,
  input  logic                        wbCycI,
  input  logic                        wbStbI,
  input  logic                        wbWeI,
  output logic                        wbAckO,
  output logic                        wbErrO,
  input  logic [DEPTH*DATA_WIDTH-1:0] hwStatusIn,
  input  logic [DEPTH*DATA_WIDTH-1:0] hwEventIn,
  output logic [DEPTH*DATA_WIDTH-1:0] regsOut,
  output logic [DEPTH-1:0]            writePulse
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  // RO wins over W1C when both are set
  localparam logic [DEPTH-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;

  logic [0:0]            r_state;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DEPTH-1:0]      r_wpulse;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_mapped;
  logic                  w_req;
  logic                  w_is_ro;
  logic                  w_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DEPTH-1:0]      w_wr_dec;

  // The subtraction wraps, so the >= test keeps addresses below the base out of range
  assign w_offset = wbAdrI - BASE_ADDR;
  assign w_idx    = w_offset[IDX_W-1:0];
  assign w_mapped = (wbAdrI >= BASE_ADDR) && ({1'b0, w_offset} < DEPTH_A);
  assign w_req    = wbCycI & wbStbI & (r_state == IDLE);

  // Decode the access: register mode, read data and per-register write strobes
  always_comb begin
    w_is_ro   = 1'b0;
    w_rd_data = '0;
    w_wr_dec  = '0;
    if (w_mapped) begin
      w_is_ro = RO_MASK[w_idx];
      if (RO_MASK[w_idx])
        w_rd_data = hwStatusIn[w_idx*DATA_WIDTH +: DATA_WIDTH];
      else
        w_rd_data = r_regs[w_idx];
    end
    w_ok = w_mapped & ~(wbWeI & w_is_ro);
    if (w_req && wbWeI && w_ok)
      w_wr_dec[w_idx] = 1'b1;
  end

  // Bus-side FSM and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
      r_wpulse <= '0;
    end else begin
      r_wpulse <= '0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= RESP;
            r_ack    <= w_ok;
            r_err    <= ~w_ok;
            r_dat    <= (w_ok && !wbWeI) ? w_rd_data : '0;
            r_wpulse <= w_wr_dec;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Per-register storage: RO holds zero, W1C merges events with set-wins, RW stores writes
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_regs[g] <= '0;
      end else if (RO_MASK[g]) begin
        r_regs[g] <= '0;
      end else if (W1C_EFF[g]) begin
        r_regs[g] <= (r_regs[g] & ~(w_wr_dec[g] ? wbDatI : '0))
                   | hwEventIn[g*DATA_WIDTH +: DATA_WIDTH];
      end else if (w_wr_dec[g]) begin
        r_regs[g] <= wbDatI;
      end
    end
    assign regsOut[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign wbAckO     = r_ack;
  assign wbErrO     = r_err;
  assign wbDatO     = r_dat;
  assign writePulse = r_wpulse;

endmodule

// File: tb/tb_wishbone_reg_bank.sv
// Directed testbench for wishbone_reg_bank with RO on register 5 and W1C on register 2.
module tb_wishbone_reg_bank;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam logic [AW-1:0] BASE = 24'hA00000;

  logic                  clk;
  logic                  rst;
  logic [AW-1:0]         wbAdrI;
  logic [DW-1:0]         wbDatI;
  logic [DW-1:0]         wbDatO;
  logic                  wbCycI, wbStbI, wbWeI;
  logic                  wbAckO, wbErrO;
  logic [DEPTH*DW-1:0]   hwStatusIn;
  logic [DEPTH*DW-1:0]   hwEventIn;
  logic [DEPTH*DW-1:0]   regsOut;
  logic [DEPTH-1:0]      writePulse;

  int n_checks = 0;
  int n_errors = 0;

  wishbone_reg_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .DEPTH(DEPTH),
    .RO_MASK(16'h0020), .W1C_MASK(16'h0004)
  ) dut (
    .clk(clk), .rst(rst), .wbAdrI(wbAdrI), .wbDatI(wbDatI), .wbDatO(wbDatO),
    .wbCycI(wbCycI), .wbStbI(wbStbI), .wbWeI(wbWeI), .wbAckO(wbAckO),
    .wbErrO(wbErrO), .hwStatusIn(hwStatusIn), .hwEventIn(hwEventIn),
    .regsOut(regsOut), .writePulse(writePulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transfer; called 1 time unit after a posedge with the bank idle.
  // ev2 is driven on register 2's event slice only during the access cycle.
  task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [DW-1:0] ev2,
                         output logic ack, output logic err, output logic [DW-1:0] rdat,
                         output logic [DEPTH-1:0] wp, output logic ack_late,
                         output logic err_late, output logic [DEPTH-1:0] wp_late);
    wbAdrI = adr; wbDatI = dat; wbWeI = we; wbCycI = 1'b1; wbStbI = 1'b1;
    hwEventIn[2*DW +: DW] = ev2;
    @(posedge clk); #1;
    ack = wbAckO; err = wbErrO; rdat = wbDatO; wp = writePulse;
    wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    hwEventIn = '0;
    @(posedge clk); #1;
    ack_late = wbAckO; err_late = wbErrO; wp_late = writePulse;
  endtask

  task automatic test_reset;
    rst = 1'b1; wbAdrI = '0; wbDatI = '0; wbCycI = 0; wbStbI = 0; wbWeI = 0;
    hwStatusIn = '0; hwEventIn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({wbAckO, wbErrO} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ackerr: got %b want 00", {wbAckO, wbErrO});
    end
    n_checks++;
    if (wbDatO !== 16'h0) begin n_errors++; $display("FAIL reset_dat: got %h want 0000", wbDatO); end
    n_checks++;
    if (writePulse !== 16'h0) begin n_errors++; $display("FAIL reset_wp: got %h want 0000", writePulse); end
    n_checks++;
    if (regsOut !== '0) begin n_errors++; $display("FAIL reset_regs: got %h want 0", regsOut); end
  endtask

  task automatic test_rw;
    logic a, e, al, el; logic [DW-1:0] d; logic [DEPTH-1:0] wp, wpl;
    wb_xfer(1'b1, BASE + 3, 16'hBEEF, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, e} !== 2'b10) begin n_errors++; $display("FAIL rw_wr_ack: got ack/err %b%b want 10", a, e); end
    n_checks++;
    if (wp !== 16'h0008) begin n_errors++; $display("FAIL rw_wpulse: got %h want 0008", wp); end
    n_checks++;
    if ({al, wpl} !== {1'b0, 16'h0}) begin
      n_errors++; $display("FAIL rw_after: got ack %b wp %h want 0 0000", al, wpl);
    end
    n_checks++;
    if (regsOut[3*DW +: DW] !== 16'hBEEF) begin
      n_errors++; $display("FAIL rw_regsout: got %h want beef", regsOut[3*DW +: DW]);
    end
    wb_xfer(1'b0, BASE + 3, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, e, d} !== {2'b10, 16'hBEEF}) begin
      n_errors++; $display("FAIL rw_rd: got ack/err %b%b data %h want 10 beef", a, e, d);
    end
    n_checks++;
    if (wp !== 16'h0) begin n_errors++; $display("FAIL rw_rd_wp: got %h want 0000", wp); end
  endtask

  task automatic test_unmapped;
    logic a, e, al, el; logic [DW-1:0] d; logic [DEPTH-1:0] wp, wpl;
    logic [DEPTH*DW-1:0] exp_regs;
    logic [AW-1:0] adrs [2];
    exp_regs = '0;
    exp_regs[3*DW +: DW] = 16'hBEEF;
    adrs[0] = BASE + 16;
    adrs[1] = BASE - 1;
    for (int i = 0; i < 2; i++) begin
      wb_xfer(1'b1, adrs[i], 16'h5A5A, 16'h0, a, e, d, wp, al, el, wpl);
      n_checks++;
      if ({a, e, wp} !== {2'b01, 16'h0}) begin
        n_errors++; $display("FAIL unmap_wr%0d: got ack/err %b%b wp %h want 01 0000", i, a, e, wp);
      end
      n_checks++;
      if (el !== 1'b0) begin n_errors++; $display("FAIL unmap_err_len%0d: got %b want 0", i, el); end
      n_checks++;
      if (regsOut !== exp_regs) begin
        n_errors++; $display("FAIL unmap_regs%0d: got %h want %h", i, regsOut, exp_regs);
      end
      wb_xfer(1'b0, adrs[i], 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
      n_checks++;
      if ({a, e, d} !== {2'b01, 16'h0}) begin
        n_errors++; $display("FAIL unmap_rd%0d: got ack/err %b%b data %h want 01 0000", i, a, e, d);
      end
    end
  endtask

  task automatic test_ro;
    logic a, e, al, el; logic [DW-1:0] d; logic [DEPTH-1:0] wp, wpl;
    hwStatusIn[5*DW +: DW] = 16'h1234;
    wb_xfer(1'b0, BASE + 5, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, e, d} !== {2'b10, 16'h1234}) begin
      n_errors++; $display("FAIL ro_rd: got ack/err %b%b data %h want 10 1234", a, e, d);
    end
    wb_xfer(1'b1, BASE + 5, 16'hFFFF, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, e, wp} !== {2'b01, 16'h0}) begin
      n_errors++; $display("FAIL ro_wr: got ack/err %b%b wp %h want 01 0000", a, e, wp);
    end
    n_checks++;
    if (regsOut[5*DW +: DW] !== 16'h0) begin
      n_errors++; $display("FAIL ro_regsout: got %h want 0000", regsOut[5*DW +: DW]);
    end
    wb_xfer(1'b0, BASE + 5, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, e, d} !== {2'b10, 16'h1234}) begin
      n_errors++; $display("FAIL ro_reread: got ack/err %b%b data %h want 10 1234", a, e, d);
    end
  endtask

  task automatic test_w1c;
    logic a, e, al, el; logic [DW-1:0] d; logic [DEPTH-1:0] wp, wpl;
    hwEventIn[2*DW +: DW] = 16'h0003;
    @(posedge clk); #1;
    hwEventIn = '0;
    wb_xfer(1'b0, BASE + 2, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, d} !== {1'b1, 16'h0003}) begin
      n_errors++; $display("FAIL w1c_set: got ack %b data %h want 1 0003", a, d);
    end
    wb_xfer(1'b1, BASE + 2, 16'h0001, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if ({a, wp} !== {1'b1, 16'h0004}) begin
      n_errors++; $display("FAIL w1c_wr: got ack %b wp %h want 1 0004", a, wp);
    end
    wb_xfer(1'b0, BASE + 2, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if (d !== 16'h0002) begin n_errors++; $display("FAIL w1c_clr: got %h want 0002", d); end
    wb_xfer(1'b1, BASE + 2, 16'h0002, 16'h0002, a, e, d, wp, al, el, wpl);
    wb_xfer(1'b0, BASE + 2, 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
    n_checks++;
    if (d !== 16'h0002) begin n_errors++; $display("FAIL w1c_setwins: got %h want 0002", d); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] pat;
    logic       data_ok;
    data_ok = 1'b1;
    wbAdrI = BASE + 3; wbWeI = 1'b0; wbCycI = 1'b1; wbStbI = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      pat[5-i] = wbAckO;
      if (wbAckO && wbDatO !== 16'hBEEF) data_ok = 1'b0;
      @(posedge clk);
    end
    #1;
    wbCycI = 1'b0; wbStbI = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (pat !== 6'b010101) begin n_errors++; $display("FAIL b2b_pattern: got %b want 010101", pat); end
    n_checks++;
    if (data_ok !== 1'b1) begin n_errors++; $display("FAIL b2b_data: read data not beef during ack"); end
  endtask

  task automatic test_reset_mid;
    logic a, e, al, el; logic [DW-1:0] d; logic [DEPTH-1:0] wp, wpl;
    wbAdrI = BASE + 0; wbDatI = 16'h5555; wbWeI = 1'b1; wbCycI = 1'b1; wbStbI = 1'b1;
    @(posedge clk); #1;
    wbCycI = 1'b0; wbStbI = 1'b0; wbWeI = 1'b0;
    n_checks++;
    if (wbAckO !== 1'b1) begin n_errors++; $display("FAIL mid_ack_before: got %b want 1", wbAckO); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({wbAckO, writePulse} !== {1'b0, 16'h0}) begin
      n_errors++; $display("FAIL mid_async_drop: got ack %b wp %h want 0 0000", wbAckO, writePulse);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (regsOut !== '0) begin n_errors++; $display("FAIL mid_regs: got %h want 0", regsOut); end
    for (int r = 0; r < 4; r++) begin
      wb_xfer(1'b0, BASE + AW'(r), 16'h0, 16'h0, a, e, d, wp, al, el, wpl);
      n_checks++;
      if ({a, d} !== {1'b1, 16'h0}) begin
        n_errors++; $display("FAIL mid_read%0d: got ack %b data %h want 1 0000", r, a, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_unmapped();
    test_ro();
    test_w1c();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Protocol invariant, counted as a failure if it ever occurs
  always @(negedge clk) begin
    if (wbAckO && wbErrO) begin
      n_errors++;
      $display("FAIL ack_err_both: got ack 1 err 1 want not both");
    end
  end

endmodule

// File: doc/wishbone_reg_bank.md
# wishbone_reg_bank

Parametrised Wishbone classic slave register bank that replaces the fixed 16 x 16-bit register file. It adds a registered single-cycle acknowledge, an error response for unmapped addresses and illegal writes, and per-register modes:
- read/write control registers;
- read-only hardware status registers;
- write-1-to-clear event registers.

It sits on the Wishbone bus driven by the Modbus-to-Wishbone bridge, in the same clock domain as the bridge.

## Interface
Parameters:
- ADDR_WIDTH, 24, width of wbAdrI.
- DATA_WIDTH, 16, register and bus data width.
- BASE_ADDR, 24'hA00000, address of register 0.
- DEPTH, 16, number of registers (1..256).
- RO_MASK, 0, DEPTH-bit mask; bit i set makes register i read-only status.
- W1C_MASK, 0, DEPTH-bit mask; bit i set makes register i a write-1-to-clear event register (RO_MASK wins if both are set).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wbAdrI  in  ADDR_WIDTH  word address.
- wbDatI  in  DATA_WIDTH  write data.
- wbDatO  out  DATA_WIDTH  read data, valid while wbAckO=1.
- wbCycI, wbStbI, wbWeI  in  1 each  Wishbone cycle, strobe, write enable.
- wbAckO  out  1  successful-transfer acknowledge.
- wbErrO  out  1  error acknowledge.
- hwStatusIn  in  DEPTH*DATA_WIDTH  status values; slice i is read through register i when RO.
- hwEventIn  in  DEPTH*DATA_WIDTH  event set pulses; slice i applies to register i when W1C.
- regsOut  out  DEPTH*DATA_WIDTH  stored register values; slice i is 0 for RO registers.
- writePulse  out  DEPTH  one-cycle pulse marking a successful write to register i.

## Operation
- Index = wbAdrI - BASE_ADDR, computed modulo 2^ADDR_WIDTH. The access is mapped iff wbAdrI >= BASE_ADDR and index < DEPTH; the subtraction does not wrap into range.
- Two-state FSM:
  - IDLE: on cycle sample with wbCycI & wbStbI, perform the access and go to RESP.
  - RESP: exactly one cycle with wbAckO or wbErrO high, then unconditionally back to IDLE.
  - Strobe still high in IDLE is a new transfer, so a held strobe gives one response every 2 cycles.
- Unmapped access, read or write: wbErrO=1, wbDatO=0, no state change.
- RW register: write stores wbDatI; read returns the stored value.
- RO register: read returns hwStatusIn slice sampled at the access edge; write gets wbErrO=1 and is ignored.
- W1C register: every cycle, bits set in the hwEventIn slice set the matching stored bits. A write clears the stored bits where wbDatI=1. If set and clear hit the same bit in the same cycle, set wins. Read returns the stored value.
- writePulse[i]=1 in the RESP cycle of any acked write to register i, never on error.
- wbAckO and wbErrO are never both high.

## Timing
- Reset (async assert, deassert sampled on clk):
  - FSM goes to IDLE.
  - wbAckO=0, wbErrO=0, wbDatO=0, writePulse=0.
  - All stored registers = 0.
- Reset during RESP drops the ack/err immediately (asynchronously).
- Latency: strobe sampled at edge N gives ack/err high after edge N, low after edge N+1.
- Register update and writePulse become visible after edge N, together with the ack.
- wbDatO is registered at edge N and holds its value until the next access.
- wbCycI low in RESP does not cancel the already-registered response.
- hwEventIn is level-sampled every edge, so a pulse must be at least 1 cycle wide.

## Test plan
- RW round trip: write 0xBEEF to BASE_ADDR+3, then read it. Required: ack 1 cycle after each strobe, read returns 0xBEEF, regsOut slice 3 = 0xBEEF, writePulse=16'h0008 for one cycle.
- Unmapped accesses: write to BASE_ADDR+16 (DEPTH=16) and to BASE_ADDR-1. Required: wbErrO=1, no ack, every regsOut slice unchanged, read of these addresses returns 0.
- RO register (RO_MASK bit 5, hwStatusIn slice 5 = 0x1234): read returns 0x1234; write of 0xFFFF gets wbErrO, no writePulse, and a re-read still returns 0x1234.
- W1C register (W1C_MASK bit 2): pulse 0x0003 on hwEventIn slice 2, so the read returns 0x0003. Write 0x0001, so the read returns 0x0002. Then write 0x0002 in the same cycle as an event 0x0002, so the read returns 0x0002 (set wins).
- Held strobe: keep wbCycI & wbStbI high for 6 cycles on reads. Required: wbAckO pattern 0,1,0,1,0,1, never high two consecutive cycles.
- Reset mid-transfer: assert rst during RESP. Required: wbAckO falls without a clock edge, and all registers read 0 after release.
